// File: rtl/proc_pkg.sv
// Shared processor constants and the fetch-unit state type, used by the fetch unit
// and the controller.
package proc_pkg;

    localparam int INST_W = 23;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BUS_W  = 16;
    localparam int LEN_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_mem.sv
// Program store: one synchronous write port and one registered read port with
// a read enable, so the output word can be held while the fetch unit is stalled.
import proc_pkg::*;

module instr_mem #(
    parameter int W  = INST_W,
    parameter int AW = ADDR_W,
    parameter int D  = DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [D];
    logic [W-1:0] r_rdata;

    // The array has no reset so it maps onto block RAM; only the output register clears.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter, load pointer and LOAD/RUN/DONE sequencing in front of the
// program store; code and address leave aligned, with no bubble between them.
import proc_pkg::*;

module instr_fetch_unit (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [INST_W-1:0] program_in,
    input  logic              start,
    input  logic              inc_pc,
    input  logic              branch,
    input  logic [BUS_W-1:0]  bus,
    output logic [INST_W-1:0] code,
    output logic [ADDR_W-1:0] address,
    output logic              code_valid,
    output logic [LEN_W-1:0]  prog_len,
    output logic              load_full,
    output logic              done
);

    fetch_state_t      r_state, w_state_next;
    logic [ADDR_W-1:0] r_pc, w_pc_next;
    logic [LEN_W-1:0]  r_prog_len, w_len_next;
    logic              r_code_valid, w_valid_next;
    logic              r_done, w_done_next;

    logic              w_full;
    logic [LEN_W-1:0]  w_target;
    logic              w_past_end;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_bus_unused;

    assign w_full       = (r_prog_len == LEN_W'(DEPTH));
    assign w_bus_unused = ^bus[BUS_W-1:ADDR_W];

    // One extra bit so that pc+1 at the top of memory reads as past the end, not as 0.
    always_comb begin
        if (branch) begin
            w_target = {1'b0, bus[ADDR_W-1:0]};
        end else if (inc_pc) begin
            w_target = {1'b0, r_pc} + LEN_W'(1);
        end else begin
            w_target = {1'b0, r_pc};
        end
    end

    assign w_past_end = (w_target >= r_prog_len);

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_len_next   = r_prog_len;
        w_valid_next = r_code_valid;
        w_done_next  = r_done;
        w_mem_we     = 1'b0;
        w_mem_waddr  = r_prog_len[ADDR_W-1:0];
        w_rd_en      = 1'b0;
        w_rd_addr    = '0;
        case (r_state)
            LOAD: begin
                if (write) begin
                    if (!w_full) begin
                        w_mem_we   = 1'b1;
                        w_len_next = r_prog_len + LEN_W'(1);
                    end
                end else if (start && (r_prog_len != '0)) begin
                    w_state_next = RUN;
                    w_pc_next    = '0;
                    w_rd_en      = 1'b1;
                    w_valid_next = 1'b1;
                end
            end
            RUN: begin
                if (w_past_end) begin
                    w_state_next = DONE;
                    w_valid_next = 1'b0;
                    w_done_next  = 1'b1;
                end else begin
                    w_pc_next = w_target[ADDR_W-1:0];
                    w_rd_en   = 1'b1;
                    w_rd_addr = w_target[ADDR_W-1:0];
                end
            end
            DONE: begin
                if (write) begin
                    w_state_next = LOAD;
                    w_mem_we     = 1'b1;
                    w_mem_waddr  = '0;
                    w_len_next   = LEN_W'(1);
                    w_done_next  = 1'b0;
                end else if (start) begin
                    w_state_next = RUN;
                    w_pc_next    = '0;
                    w_rd_en      = 1'b1;
                    w_valid_next = 1'b1;
                    w_done_next  = 1'b0;
                end
            end
            default: begin
                w_state_next = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= LOAD;
            r_pc         <= '0;
            r_prog_len   <= '0;
            r_code_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_prog_len   <= w_len_next;
            r_code_valid <= w_valid_next;
            r_done       <= w_done_next;
        end
    end

    instr_mem #(
        .W  (INST_W),
        .AW (ADDR_W),
        .D  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (program_in),
        .i_re    (w_rd_en),
        .i_raddr (w_rd_addr),
        .o_rdata (code)
    );

    assign address    = r_pc;
    assign code_valid = r_code_valid;
    assign prog_len   = r_prog_len;
    assign load_full  = w_full;
    assign done       = r_done;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// transaction-level model of the fetch unit.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write = 1'b0;
    logic [22:0] program_in = '0;
    logic        start = 1'b0;
    logic        inc_pc = 1'b0;
    logic        branch = 1'b0;
    logic [15:0] bus = '0;
    logic [22:0] code;
    logic [5:0]  address;
    logic        code_valid;
    logic [6:0]  prog_len;
    logic        load_full;
    logic        done;

    instr_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .write      (write),
        .program_in (program_in),
        .start      (start),
        .inc_pc     (inc_pc),
        .branch     (branch),
        .bus        (bus),
        .code       (code),
        .address    (address),
        .code_valid (code_valid),
        .prog_len   (prog_len),
        .load_full  (load_full),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model: 0 = loading, 1 = running, 2 = finished.
    int          m_mode;
    int          m_pc;
    int          m_len;
    logic [22:0] m_code;
    bit          m_valid;
    bit          m_done;
    logic [22:0] m_mem [64];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_len = 0; m_code = '0; m_valid = 0; m_done = 0;
    endtask

    task automatic model_begin_run();
        m_mode = 1; m_pc = 0; m_code = m_mem[0]; m_valid = 1; m_done = 0;
    endtask

    task automatic model_step(input bit w, input logic [22:0] p, input bit s,
                              input bit i, input bit b, input logic [15:0] bs);
        int tgt;
        case (m_mode)
            0: begin
                if (w) begin
                    if (m_len < 64) begin
                        m_mem[m_len] = p;
                        m_len++;
                    end
                end else if (s && m_len > 0) begin
                    model_begin_run();
                end
            end
            1: begin
                tgt = b ? int'(bs) % 64 : (i ? m_pc + 1 : m_pc);
                if (tgt >= m_len) begin
                    m_mode = 2; m_valid = 0; m_done = 1;
                end else begin
                    m_pc = tgt; m_code = m_mem[tgt];
                end
            end
            default: begin
                if (w) begin
                    m_mem[0] = p; m_len = 1; m_mode = 0; m_done = 0;
                end else if (s) begin
                    model_begin_run();
                end
            end
        endcase
    endtask

    task automatic check_all();
        check_eq("address", 32'(address), 32'(m_pc));
        check_eq("code", 32'(code), 32'(m_code));
        check_eq("code_valid", 32'(code_valid), 32'(m_valid));
        check_eq("prog_len", 32'(prog_len), 32'(m_len));
        check_eq("load_full", 32'(load_full), 32'(m_len == 64));
        check_eq("done", 32'(done), 32'(m_done));
    endtask

    // One clock transaction: drive, clock, advance the model, compare.
    task automatic cycle(input bit w, input logic [22:0] p, input bit s,
                         input bit i, input bit b, input logic [15:0] bs);
        write = w; program_in = p; start = s; inc_pc = i; branch = b; bus = bs;
        @(posedge clk);
        model_step(w, p, s, i, b, bs);
        #1;
        $display("t=%0t wr=%0b pin=%h st=%0b inc=%0b br=%0b bus=%h -> addr=%0d code=%h v=%0b len=%0d full=%0b done=%0b",
                 $time, w, p, s, i, b, bs, address, code, code_valid, prog_len, load_full, done);
        check_all();
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before the next edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [15:0] rbus;
        logic [22:0] rword;
        int          tgt;

        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Three-word program, start, step through to the end.
        cycle(1, 23'h000001, 0, 0, 0, '0);
        cycle(1, 23'h000002, 0, 0, 0, '0);
        cycle(1, 23'h000003, 0, 0, 0, '0);
        cycle(0, '0, 1, 0, 0, '0);
        check_eq("start_addr", 32'(address), 32'd0);
        check_eq("start_code", 32'(code), 32'h1);
        check_eq("start_valid", 32'(code_valid), 32'd1);
        check_eq("start_len", 32'(prog_len), 32'd3);
        cycle(0, '0, 0, 1, 0, '0);
        check_eq("inc1_code", 32'(code), 32'h2);
        cycle(0, '0, 0, 1, 0, '0);
        check_eq("inc2_code", 32'(code), 32'h3);
        cycle(0, '0, 0, 1, 0, '0);
        check_eq("end_done", 32'(done), 32'd1);
        check_eq("end_valid", 32'(code_valid), 32'd0);
        check_eq("end_addr", 32'(address), 32'd2);

        // Reload 8 words from DONE, branch with inc_pc also high and upper bus bits set.
        for (int k = 0; k < 8; k++) cycle(1, 23'(32'h100 + k), 0, 0, 0, '0);
        cycle(0, '0, 1, 0, 0, '0);
        cycle(0, '0, 0, 1, 1, 16'hFF05);
        check_eq("br_addr", 32'(address), 32'd5);
        check_eq("br_code", 32'(code), 32'h105);

        // Branch past a 4-word program, then re-run without reload.
        cycle(0, '0, 0, 0, 1, 16'd60);
        for (int k = 0; k < 4; k++) cycle(1, 23'(32'h200 + k), 0, 0, 0, '0);
        cycle(0, '0, 1, 0, 0, '0);
        cycle(0, '0, 0, 0, 1, 16'd6);
        check_eq("br6_done", 32'(done), 32'd1);
        cycle(0, '0, 1, 0, 0, '0);
        check_eq("rerun_addr", 32'(address), 32'd0);
        check_eq("rerun_code", 32'(code), 32'h200);
        check_eq("rerun_done", 32'(done), 32'd0);

        // Fill the store, overflow by one, then write+start together.
        async_reset();
        for (int k = 0; k < 65; k++) cycle(1, 23'($urandom), 0, 0, 0, '0);
        check_eq("fill_len", 32'(prog_len), 32'd64);
        check_eq("fill_full", 32'(load_full), 32'd1);
        cycle(1, 23'h7FFFFF, 1, 0, 0, '0);
        check_eq("wr_start_valid", 32'(code_valid), 32'd0);
        cycle(0, '0, 0, 0, 1, 16'd63);
        cycle(0, '0, 1, 0, 0, '0);
        cycle(0, '0, 0, 0, 1, 16'd63);
        cycle(0, '0, 0, 1, 0, '0);
        check_eq("top_overflow_done", 32'(done), 32'd1);

        // Reset mid-run at address 2.
        cycle(0, '0, 1, 0, 0, '0);
        cycle(0, '0, 0, 1, 0, '0);
        cycle(0, '0, 0, 1, 0, '0);
        check_eq("pre_rst_addr", 32'(address), 32'd2);
        async_reset();
        cycle(0, '0, 0, 1, 0, '0);
        check_eq("post_rst_addr", 32'(address), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                rbus  = 16'($urandom);
                tgt   = $urandom_range(0, m_len + 2);
                rbus[5:0] = 6'(tgt);
                rword = 23'($urandom);
                cycle($urandom_range(0, 99) < 20, rword, $urandom_range(0, 99) < 12,
                      $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 10, rbus);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
